// File: rtl/decode_pkg.sv
// ---------------------------------------------------------------------------
// decode_pkg
//
// Shared types for the RV32I decode stage.
//   opclass_t     - coarse instruction class handed to execute
//   alu_op_t      - ALU operation; for BRANCH/LOAD/STORE the low three bits
//                   carry funct3 unchanged. M-extension codes are always
//                   defined, even when the decoder does not emit them.
//   OPC_*         - RV32I major opcodes (inst[6:0])
//   decoded_op_t  - complete decoded payload minus the PC
//   alu_from_funct3 - funct3 to ALU op mapping for OP / OP-IMM
// ---------------------------------------------------------------------------
package decode_pkg;

    localparam int IMM_W = 32;

    typedef enum logic [3:0] {
        OC_LUI     = 4'd0,
        OC_AUIPC   = 4'd1,
        OC_JAL     = 4'd2,
        OC_JALR    = 4'd3,
        OC_BRANCH  = 4'd4,
        OC_LOAD    = 4'd5,
        OC_STORE   = 4'd6,
        OC_OPIMM   = 4'd7,
        OC_OP      = 4'd8,
        OC_FENCE   = 4'd9,
        OC_SYSTEM  = 4'd10,
        OC_ILLEGAL = 4'd11
    } opclass_t;

    // M ops sit at 16..23 so that the M code is simply {2'b10, funct3}.
    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_MUL    = 5'd16,
        ALU_MULH   = 5'd17,
        ALU_MULHSU = 5'd18,
        ALU_MULHU  = 5'd19,
        ALU_DIV    = 5'd20,
        ALU_DIVU   = 5'd21,
        ALU_REM    = 5'd22,
        ALU_REMU   = 5'd23
    } alu_op_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        opclass_t         opclass;
        alu_op_t          alu_op;
        logic [4:0]       rd;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [IMM_W-1:0] imm;
        logic             we;
        logic             illegal;
    } decoded_op_t;

    // 'alt' selects SUB over ADD and SRA over SRL.
    function automatic alu_op_t alu_from_funct3(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_rv32_decoder.sv
// ---------------------------------------------------------------------------
// rv32_decoder
//
// Purely combinational RV32I instruction decoder.
//   inst - 32-bit instruction word
//   op   - decoded payload (class, ALU op, register indices, immediate,
//          write enable, illegal flag)
// Build option: DECODE_RV32M_EN enables decoding of the M extension
// (OP with funct7 = 0000001); without it those encodings are illegal.
// rs1/rs2 always carry the raw instruction fields; rd is zeroed whenever
// the op does not write the register file.
// ---------------------------------------------------------------------------
module rv32_decoder
    import decode_pkg::*;
(
    input  logic [31:0] inst,
    output decoded_op_t op
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic        legal;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // Opcode selects class, immediate format and write enable; the field
    // checks for each class decide legality. Opcode includes inst[1:0], so
    // compressed/non-32-bit encodings fall into the default branch.
    always_comb begin
        op         = '0;
        op.opclass = OC_ILLEGAL;
        op.alu_op  = ALU_ADD;
        op.rs1     = inst[19:15];
        op.rs2     = inst[24:20];
        legal      = 1'b1;

        case (opcode)
            OPC_LUI: begin
                op.opclass = OC_LUI;
                op.imm     = imm_u;
                op.we      = 1'b1;
            end
            OPC_AUIPC: begin
                op.opclass = OC_AUIPC;
                op.imm     = imm_u;
                op.we      = 1'b1;
            end
            OPC_JAL: begin
                op.opclass = OC_JAL;
                op.imm     = imm_j;
                op.we      = 1'b1;
            end
            OPC_JALR: begin
                op.opclass = OC_JALR;
                op.imm     = imm_i;
                op.we      = 1'b1;
                legal      = (funct3 == 3'd0);
            end
            OPC_BRANCH: begin
                op.opclass = OC_BRANCH;
                op.alu_op  = alu_op_t'({2'b00, funct3});
                op.imm     = imm_b;
                legal      = (funct3[2:1] != 2'b01);
            end
            OPC_LOAD: begin
                op.opclass = OC_LOAD;
                op.alu_op  = alu_op_t'({2'b00, funct3});
                op.imm     = imm_i;
                op.we      = 1'b1;
                legal      = !((funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7));
            end
            OPC_STORE: begin
                op.opclass = OC_STORE;
                op.alu_op  = alu_op_t'({2'b00, funct3});
                op.imm     = imm_s;
                legal      = (funct3 <= 3'd2);
            end
            OPC_OPIMM: begin
                op.opclass = OC_OPIMM;
                op.imm     = imm_i;
                op.we      = 1'b1;
                // Only the shifts reinterpret the upper immediate bits.
                op.alu_op  = alu_from_funct3(funct3, (funct3 == 3'd5) && funct7[5]);
                if (funct3 == 3'd1) begin
                    legal = (funct7 == 7'b0000000);
                end else if (funct3 == 3'd5) begin
                    legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                end
            end
            OPC_OP: begin
                op.opclass = OC_OP;
                op.we      = 1'b1;
                if (funct7 == 7'b0000000) begin
                    op.alu_op = alu_from_funct3(funct3, 1'b0);
                end else if ((funct7 == 7'b0100000) && ((funct3 == 3'd0) || (funct3 == 3'd5))) begin
                    op.alu_op = alu_from_funct3(funct3, 1'b1);
`ifdef DECODE_RV32M_EN
                end else if (funct7 == 7'b0000001) begin
                    op.alu_op = alu_op_t'({2'b10, funct3});
`endif
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_FENCE: begin
                op.opclass = OC_FENCE;
                op.imm     = imm_i;
            end
            OPC_SYSTEM: begin
                op.opclass = OC_SYSTEM;
                op.imm     = imm_i;
            end
            default: begin
                legal = 1'b0;
            end
        endcase

        // Illegal ops still flow down the pipe so execute can raise the trap.
        if (!legal) begin
            op.opclass = OC_ILLEGAL;
            op.alu_op  = ALU_ADD;
            op.imm     = '0;
            op.we      = 1'b0;
            op.illegal = 1'b1;
        end

        op.rd = op.we ? inst[11:7] : 5'd0;
    end

endmodule

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//
// RV32I decode stage: one-entry pipeline register around rv32_decoder with
// valid/ready handshakes on both sides and a redirect flush.
// Ports:
//   clk, reset_n            - clock, synchronous active-low reset
//   flush                   - drop held and incoming instruction
//   in_valid/in_ready       - upstream handshake (fetch)
//   in_inst, in_pc          - instruction word and its PC
//   out_valid/out_ready     - downstream handshake (execute)
//   out_pc, out_opclass, out_alu_op, out_rd, out_rs1, out_rs2,
//   out_imm, out_we, out_illegal - registered decoded micro-op
// Build option: DECODE_RV32M_EN (see rv32_decoder).
// ---------------------------------------------------------------------------
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [3:0]      out_opclass,
    output logic [4:0]      out_alu_op,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic            out_we,
    output logic            out_illegal
);

    decoded_op_t     dec;
    decoded_op_t     held;
    logic [XLEN-1:0] pc_q;
    logic            capture;

    rv32_decoder u_decoder (
        .inst (in_inst),
        .op   (dec)
    );

    // The slot frees up in the same cycle execute takes the current op, so
    // a full-rate stream never sees a bubble.
    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    // Valid bit: flush wins over a capture; a drain clears it. Payload only
    // moves on capture, so it stays stable for as long as the op is held.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            held      <= '0;
            pc_q      <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (capture) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (capture) begin
                held <= dec;
                pc_q <= in_pc;
            end
        end
    end

    assign out_pc      = pc_q;
    assign out_opclass = held.opclass;
    assign out_alu_op  = held.alu_op;
    assign out_rd      = held.rd;
    assign out_rs1     = held.rs1;
    assign out_rs2     = held.rs2;
    assign out_imm     = held.imm;
    assign out_we      = held.we;
    assign out_illegal = held.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
//
// Self-checking bench for decode_stage: directed vectors, stall, flush,
// reset-during-stall and a randomized stream checked against a behavioural
// model of the decode rules and the one-entry handshake.
// Build option: DECODE_RV32M_EN must match the build of the design.
// ---------------------------------------------------------------------------
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [3:0]  out_opclass;
    logic [4:0]  out_alu_op;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [31:0] out_imm;
    logic        out_we;
    logic        out_illegal;

    int checks = 0;
    int passed = 0;

    logic [89:0] obs;
    assign obs = {out_opclass, out_alu_op, out_rd, out_rs1, out_rs2, out_imm, out_we, out_illegal, out_pc};

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_opclass (out_opclass),
        .out_alu_op  (out_alu_op),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_imm     (out_imm),
        .out_we      (out_we),
        .out_illegal (out_illegal)
    );

    // Reference decode written straight from the ISA rules: immediates are
    // built arithmetically, classes numbered LUI=0 .. ILLEGAL=11, ALU codes
    // ADD=0..AND=9 and MUL..REMU=16..23.
    function automatic logic [89:0] model(input logic [31:0] i, input logic [31:0] pc);
        int alu_tab[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        logic signed [31:0] s;
        int cls;
        int alu;
        int imm;
        int f3;
        int f7;
        bit we;
        bit ok;
        logic [4:0]  rd;
        logic [31:0] immv;
        logic [3:0]  clsv;
        logic [4:0]  aluv;
        s   = i;
        f3  = int'(i[14:12]);
        f7  = int'(i[31:25]);
        cls = 11;
        alu = 0;
        imm = 0;
        we  = 0;
        ok  = 1;
        case (i[6:0])
            7'h37: begin cls = 0; imm = int'(i & 32'hFFFFF000); we = 1; end
            7'h17: begin cls = 1; imm = int'(i & 32'hFFFFF000); we = 1; end
            7'h6F: begin
                cls = 2; we = 1;
                imm = (i[31] ? -(1 << 20) : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
            end
            7'h67: begin cls = 3; imm = int'(s >>> 20); we = 1; ok = (f3 == 0); end
            7'h63: begin
                cls = 4; alu = f3; ok = !(f3 == 2 || f3 == 3);
                imm = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
            end
            7'h03: begin cls = 5; alu = f3; imm = int'(s >>> 20); we = 1; ok = (f3 inside {0, 1, 2, 4, 5}); end
            7'h23: begin cls = 6; alu = f3; imm = int'(s >>> 25) * 32 + int'(i[11:7]); ok = (f3 < 3); end
            7'h13: begin
                cls = 7; imm = int'(s >>> 20); we = 1; alu = alu_tab[f3];
                if (f3 == 5 && f7 == 32) alu = 7;
                if (f3 == 1) ok = (f7 == 0);
                if (f3 == 5) ok = (f7 == 0 || f7 == 32);
            end
            7'h33: begin
                cls = 8; we = 1;
                if (f7 == 0) alu = alu_tab[f3];
                else if (f7 == 32 && f3 == 0) alu = 1;
                else if (f7 == 32 && f3 == 5) alu = 7;
`ifdef DECODE_RV32M_EN
                else if (f7 == 1) alu = 16 + f3;
`endif
                else ok = 0;
            end
            7'h0F: begin cls = 9;  imm = int'(s >>> 20); end
            7'h73: begin cls = 10; imm = int'(s >>> 20); end
            default: ok = 0;
        endcase
        if (!ok) begin
            cls = 11; alu = 0; imm = 0; we = 0;
        end
        rd   = we ? i[11:7] : 5'd0;
        immv = imm;
        clsv = cls[3:0];
        aluv = alu[4:0];
        return {clsv, aluv, rd, i[19:15], i[24:20], immv, we, !ok, pc};
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [6:0] opcs[11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
        logic [31:0] w;
        int r;
        w = $urandom;
        r = $urandom_range(0, 9);
        if (r < 8) w[6:0] = opcs[$urandom_range(0, 10)];
        if (r < 5) begin
            case ($urandom_range(0, 3))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                2: w[31:25] = 7'h01;
                default: ;
            endcase
        end
        return w;
    endfunction

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        in_valid  = v;
        in_inst   = inst;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, $urandom, $urandom, 1'($urandom), 1'b0);
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", out_valid);
        else passed++;
        checks++;
        if (obs !== 90'd0) $display("[TB] FAIL reset_outputs: got %h expected 0", obs);
        else passed++;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        #1;
        checks++;
        if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        else passed++;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Known encodings with hand-derived key fields:
    // {opclass, alu_op, rd, imm, we, illegal}.
    task automatic test_directed();
        logic [31:0] insts[6] = '{32'h00500093, 32'hFE20AE23, 32'hFE000EE3, 32'h022081B3, 32'h00000000, 32'hFFFFFFFF};
        logic [47:0] keys[6];
        logic [89:0] exp_obs;
        logic [47:0] key_obs;
        keys[0] = {4'd7, 5'd0, 5'd1, 32'h00000005, 1'b1, 1'b0};
        keys[1] = {4'd6, 5'd2, 5'd0, 32'hFFFFFFFC, 1'b0, 1'b0};
        keys[2] = {4'd4, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b0, 1'b0};
`ifdef DECODE_RV32M_EN
        keys[3] = {4'd8, 5'd16, 5'd3, 32'h00000000, 1'b1, 1'b0};
`else
        keys[3] = {4'd11, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b1};
`endif
        keys[4] = {4'd11, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b1};
        keys[5] = {4'd11, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b1};
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, insts[k], 32'h100 + 32'(k * 4), 1'b1, 1'b0);
            @(posedge clk);
            @(negedge clk);
            drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
            exp_obs = model(insts[k], 32'h100 + 32'(k * 4));
            key_obs = {out_opclass, out_alu_op, out_rd, out_imm, out_we, out_illegal};
            checks++;
            if (out_valid !== 1'b1) $display("[TB] FAIL directed_valid[%0d]: got %b expected 1", k, out_valid);
            else passed++;
            checks++;
            if (key_obs !== keys[k]) $display("[TB] FAIL directed_key[%0d] inst %h: got %h expected %h", k, insts[k], key_obs, keys[k]);
            else passed++;
            checks++;
            if (obs !== exp_obs) $display("[TB] FAIL directed_model[%0d] inst %h: got %h expected %h", k, insts[k], obs, exp_obs);
            else passed++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_stall();
        logic [31:0] a = 32'h00500093;
        logic [31:0] b = 32'hFE20AE23;
        drive(1'b1, a, 32'h200, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, b, 32'h204, 1'b0, 1'b0);
            #1;
            checks++;
            if (in_ready !== 1'b0) $display("[TB] FAIL stall_in_ready[%0d]: got %b expected 0", k, in_ready);
            else passed++;
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || obs !== model(a, 32'h200))
                $display("[TB] FAIL stall_hold[%0d]: got v=%b %h expected v=1 %h", k, out_valid, obs, model(a, 32'h200));
            else passed++;
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) $display("[TB] FAIL stall_release_ready: got %b expected 1", in_ready);
        else passed++;
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || obs !== model(b, 32'h204))
            $display("[TB] FAIL stall_next_op: got v=%b %h expected v=1 %h", out_valid, obs, model(b, 32'h204));
        else passed++;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) $display("[TB] FAIL stall_no_duplicate: got %b expected 0", out_valid);
        else passed++;
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h00500093, 32'h300, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 32'hFE000EE3, 32'h304, 1'b1, 1'b1);
        #1;
        checks++;
        if (in_ready !== 1'b1) $display("[TB] FAIL flush_in_ready: got %b expected 1", in_ready);
        else passed++;
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0) $display("[TB] FAIL flush_valid: got %b expected 0", out_valid);
        else passed++;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) $display("[TB] FAIL flush_dropped: got %b expected 0", out_valid);
        else passed++;

        // Reset in the middle of a stall.
        drive(1'b1, 32'hFE20AE23, 32'h400, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 32'h00500093, 32'h404, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || obs !== 90'd0)
            $display("[TB] FAIL reset_mid_stall: got v=%b %h expected v=0 0", out_valid, obs);
        else passed++;
        reset_n = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        bit          m_valid = 0;
        logic [89:0] m_obs = '0;
        bit          fire;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        v;
        logic        ordy;
        logic        fl;
        for (int n = 0; n < 600; n++) begin
            inst = gen_inst();
            pc   = $urandom & 32'hFFFFFFFC;
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 15) == 0);
            drive(v, inst, pc, ordy, fl);
            #1;
            checks++;
            if (in_ready !== (!m_valid || ordy)) $display("[TB] FAIL rand_in_ready[%0d]: got %b expected %b", n, in_ready, (!m_valid || ordy));
            else passed++;
            fire = v && (!m_valid || ordy) && !fl;
            @(posedge clk);
            if (fl) m_valid = 0;
            else if (fire) begin
                m_valid = 1;
                m_obs   = model(inst, pc);
            end else if (ordy) m_valid = 0;
            @(negedge clk);
            checks++;
            if (out_valid !== m_valid) $display("[TB] FAIL rand_valid[%0d]: got %b expected %b", n, out_valid, m_valid);
            else passed++;
            if (m_valid) begin
                checks++;
                if (obs !== m_obs) $display("[TB] FAIL rand_payload[%0d]: got %h expected %h", n, obs, m_obs);
                else passed++;
            end
        end
    endtask

    initial begin
        $display("[TB] decode_stage bench start");
        reset_n = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        test_reset();
        test_directed();
        test_stall();
        test_flush();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
